mem_dp_pipe: RTL and testbench
==============================

Name: mem_dp_pipe

Overview:
- Parametrised dual-port memory for the RV32I core; next generation of the core's instruction/data RAM.
- Instruction port: aligned 32-bit reads only. Data port: byte/half/word loads with sign or zero extension, and byte-lane stores.
- Adds configurable pipelined read latency, a request/response valid handshake, and misaligned-access error reporting.

Parameters:
ADDR_W, 14, byte-address width; depth = 2**(ADDR_W-2) 32-bit words.
LATENCY, 1, request-to-response cycles on both ports; legal range 1..4.

Ports:
clk  input  1  clock
resetn  input  1  synchronous active-low reset
i_req  input  1  fetch request, one per cycle max
i_addr  input  ADDR_W  fetch byte address; bits [1:0] ignored
i_valid  output  1  fetch response valid
i_rdata  output  32  fetched word
d_req  input  1  data request, one per cycle max
d_we  input  1  1 = store, 0 = load
d_size  input  2  00 byte, 01 half, 10 word, 11 reserved
d_unsigned  input  1  load zero-extends when 1, sign-extends when 0
d_addr  input  ADDR_W  data byte address
d_wdata  input  32  store data, right-aligned (low bits)
d_valid  output  1  data response valid (loads and stores)
d_rdata  output  32  extended load result; 0 for stores and errors
d_err  output  1  misaligned or reserved-size access, qualified by d_valid

Behaviour:
- Reset: resetn sampled only at posedge clk. While low: i_valid=0, d_valid=0, i_rdata=0, d_rdata=0, d_err=0; all pipeline stages flushed; memory array not cleared.
- Reset mid-operation: in-flight requests are dropped, with no response after reset releases. A store is not performed if its request is accepted in a cycle with resetn=0.
- Throughput: each port accepts one request per cycle, fully pipelined; no ready signal, never stalls.
- Latency: a request at edge N produces a response at edge N+LATENCY (valid high exactly one cycle per request). Responses return in order. Back-to-back requests give back-to-back responses.
- Fetch: word index = i_addr[ADDR_W-1:2]; i_rdata = mem[index].
- Data word index: d_addr[ADDR_W-1:2]; lane = d_addr[1:0].
- Alignment:
  - Byte: any lane.
  - Half: lane 0 or 2.
  - Word: lane 0.
  - Any other lane, or d_size=11, is an error: no memory change, response with d_err=1, d_rdata=0.
- Store: written at the accept edge using byte enables. Byte writes d_wdata[7:0] into lane. Half writes d_wdata[15:0] into lanes lane..lane+1. Word writes all lanes. Other bytes are unchanged. Response: d_valid, d_err=0, d_rdata=0.
- Load: word is read at the accept edge. The selected byte or half is shifted to bit 0, then extended per d_unsigned. Word loads ignore d_unsigned.
- Load after store to the same address on the data port: a load accepted the cycle after a store sees the new data.
- Same-cycle fetch of the word being stored by the data port: i_rdata returns the pre-store word (read-first), unless MEM_FWD_EN is defined.
- Latency pipeline: LATENCY-1 register stages after the array read, each carrying valid, rdata and err. Array read data counts as stage 1.

Optional Feature:
- Macro: MEM_FWD_EN.
- Defined: a same-cycle fetch hitting the data-store word returns the merged post-store word (write-first forwarding, byte-lane accurate).
- Undefined: read-first as above; no forwarding logic synthesised.

Test Plan:
1. LATENCY=1. Store word 0xDEADBEEF @0x0010, then load word @0x0010 next cycle -> d_valid one cycle after each request; load d_rdata=0xDEADBEEF, d_err=0.
2. Store byte 0x80 @0x0013 over 0x11223344; load byte signed @0x0013 -> 0xFFFFFF80; load byte unsigned -> 0x00000080; load word -> 0x80223344.
3. Load half @0x0011 and store word @0x0012 -> both responses d_err=1, d_rdata=0; word @0x0010 unchanged.
4. LATENCY=3. Four back-to-back fetches @0x0,0x4,0x8,0xC holding 1,2,3,4 -> i_valid high for four consecutive cycles starting 3 cycles after the first request; data in order 1,2,3,4.
5. LATENCY=3. Issue two loads, assert resetn=0 for one cycle before they return -> no d_valid ever appears for them; outputs 0 during reset.
6. Same-cycle fetch @0x0020 and store half 0xABCD @0x0022 over 0x00000000 -> i_rdata=0x00000000 without MEM_FWD_EN, 0xABCD0000 with it; next fetch returns 0xABCD0000.

Source files
------------

// File: rtl/mem_dp_pipe.sv
// Dual-port RV32I instruction/data RAM with pipelined read latency and misalignment errors.
// Define MEM_FWD_EN to forward a same-cycle data store into a fetch of the same word.
module mem_dp_pipe #(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned LATENCY = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_valid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_valid,
    output logic [31:0]       d_rdata,
    output logic              d_err
);

    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned DEPTH = 2 ** IDX_W;

    logic [31:0] mem [DEPTH];

    logic [IDX_W-1:0] i_idx;
    logic [IDX_W-1:0] d_idx;
    logic [1:0]       lane;
    logic             d_ok;
    logic [3:0]       be;
    logic [31:0]      wdata_al;
    logic             st_en;
    logic [31:0]      d_word;
    logic [31:0]      ld_shift;
    logic [31:0]      ld_data;
    logic [31:0]      d_rd0;
    logic [31:0]      i_word;
    logic             i_addr_unused;

    assign i_idx         = i_addr[ADDR_W-1:2];
    assign d_idx         = d_addr[ADDR_W-1:2];
    assign lane          = d_addr[1:0];
    assign i_addr_unused = ^i_addr[1:0];

    // Alignment check, byte enables and lane-replicated store data
    always_comb begin
        d_ok     = 1'b0;
        be       = 4'b0000;
        wdata_al = d_wdata;
        case (d_size)
            2'b00: begin
                d_ok     = 1'b1;
                be       = 4'b0001 << lane;
                wdata_al = {4{d_wdata[7:0]}};
            end
            2'b01: begin
                d_ok     = ~lane[0];
                be       = 4'b0011 << lane;
                wdata_al = {2{d_wdata[15:0]}};
            end
            2'b10: begin
                d_ok     = (lane == 2'b00);
                be       = 4'b1111;
                wdata_al = d_wdata;
            end
            default: begin
                d_ok     = 1'b0;
                be       = 4'b0000;
                wdata_al = d_wdata;
            end
        endcase
    end

    // A store accepted while reset is asserted must not touch the array
    assign st_en = resetn & d_req & d_we & d_ok;

    always_ff @(posedge clk) begin
        if (st_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[d_idx][8*b +: 8] <= wdata_al[8*b +: 8];
                end
            end
        end
    end

    assign d_word   = mem[d_idx];
    assign ld_shift = d_word >> {lane, 3'b000};

    always_comb begin
        case (d_size)
            2'b00:   ld_data = d_unsigned ? {24'b0, ld_shift[7:0]}
                                          : {{24{ld_shift[7]}}, ld_shift[7:0]};
            2'b01:   ld_data = d_unsigned ? {16'b0, ld_shift[15:0]}
                                          : {{16{ld_shift[15]}}, ld_shift[15:0]};
            default: ld_data = d_word;
        endcase
    end

    assign d_rd0 = (d_req && !d_we && d_ok) ? ld_data : 32'b0;

`ifdef MEM_FWD_EN
    always_comb begin
        i_word = mem[i_idx];
        if (st_en && (i_idx == d_idx)) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    i_word[8*b +: 8] = wdata_al[8*b +: 8];
                end
            end
        end
    end
`else
    assign i_word = mem[i_idx];
`endif

    logic [LATENCY-1:0]       i_v_q;
    logic [LATENCY-1:0][31:0] i_d_q;
    logic [LATENCY-1:0]       d_v_q;
    logic [LATENCY-1:0][31:0] d_d_q;
    logic [LATENCY-1:0]       d_e_q;

    // Stage 0 holds the array read; later stages only add latency
    always_ff @(posedge clk) begin
        if (!resetn) begin
            i_v_q <= '0;
            i_d_q <= '0;
            d_v_q <= '0;
            d_d_q <= '0;
            d_e_q <= '0;
        end else begin
            i_v_q[0] <= i_req;
            i_d_q[0] <= i_req ? i_word : 32'b0;
            d_v_q[0] <= d_req;
            d_d_q[0] <= d_rd0;
            d_e_q[0] <= d_req & ~d_ok;
            for (int unsigned k = 1; k < LATENCY; k++) begin
                i_v_q[k] <= i_v_q[k-1];
                i_d_q[k] <= i_d_q[k-1];
                d_v_q[k] <= d_v_q[k-1];
                d_d_q[k] <= d_d_q[k-1];
                d_e_q[k] <= d_e_q[k-1];
            end
        end
    end

    assign i_valid = i_v_q[LATENCY-1];
    assign i_rdata = i_d_q[LATENCY-1];
    assign d_valid = d_v_q[LATENCY-1];
    assign d_rdata = d_d_q[LATENCY-1];
    assign d_err   = d_e_q[LATENCY-1];

endmodule

// File: tb/tb_mem_dp_pipe.sv
// Bench for mem_dp_pipe: unit 0 has LATENCY=1, unit 1 has LATENCY=3.
// Expected responses are queued with their due cycle and checked as they emerge.
module tb_mem_dp_pipe;

    localparam int unsigned AW = 14;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn     [2];
    logic          i_req      [2];
    logic [AW-1:0] i_addr     [2];
    logic          i_valid    [2];
    logic [31:0]   i_rdata    [2];
    logic          d_req      [2];
    logic          d_we       [2];
    logic [1:0]    d_size     [2];
    logic          d_unsigned [2];
    logic [AW-1:0] d_addr     [2];
    logic [31:0]   d_wdata    [2];
    logic          d_valid    [2];
    logic [31:0]   d_rdata    [2];
    logic          d_err      [2];

    mem_dp_pipe #(.ADDR_W(AW), .LATENCY(1)) u_lat1 (
        .clk(clk), .resetn(resetn[0]),
        .i_req(i_req[0]), .i_addr(i_addr[0]), .i_valid(i_valid[0]), .i_rdata(i_rdata[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_size(d_size[0]), .d_unsigned(d_unsigned[0]),
        .d_addr(d_addr[0]), .d_wdata(d_wdata[0]), .d_valid(d_valid[0]),
        .d_rdata(d_rdata[0]), .d_err(d_err[0])
    );

    mem_dp_pipe #(.ADDR_W(AW), .LATENCY(3)) u_lat3 (
        .clk(clk), .resetn(resetn[1]),
        .i_req(i_req[1]), .i_addr(i_addr[1]), .i_valid(i_valid[1]), .i_rdata(i_rdata[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_size(d_size[1]), .d_unsigned(d_unsigned[1]),
        .d_addr(d_addr[1]), .d_wdata(d_wdata[1]), .d_valid(d_valid[1]),
        .d_rdata(d_rdata[1]), .d_err(d_err[1])
    );

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t dq0[$];
    exp_t dq1[$];
    exp_t iq0[$];
    exp_t iq1[$];
    exp_t me;
    logic rs_q [2];

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rs_q[0]  <= resetn[0];
        rs_q[1]  <= resetn[1];
    end

    function automatic int lat(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    // Response monitor: every comparison of the bench lives here
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rs_q[u] === 1'b0) begin
                total++;
                if (i_valid[u] !== 1'b0 || i_rdata[u] !== 32'h0 || d_valid[u] !== 1'b0 ||
                    d_rdata[u] !== 32'h0 || d_err[u] !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_out%0d: got iv=%b id=%h dv=%b dd=%h de=%b, want all 0",
                             u, i_valid[u], i_rdata[u], d_valid[u], d_rdata[u], d_err[u]);
                end
            end
        end
        if (d_valid[0] === 1'b1) begin
            total++;
            if (dq0.size() == 0) begin
                bad++;
                $display("FAIL d0_resp: got unexpected data=%h err=%b at cycle %0d, want none",
                         d_rdata[0], d_err[0], cyc);
            end else begin
                me = dq0.pop_front();
                if (d_rdata[0] !== me.data || d_err[0] !== me.err || cyc != me.due) begin
                    bad++;
                    $display("FAIL d0_resp: got data=%h err=%b cyc=%0d, want data=%h err=%b cyc=%0d",
                             d_rdata[0], d_err[0], cyc, me.data, me.err, me.due);
                end
            end
        end else if (dq0.size() != 0 && dq0[0].due <= cyc) begin
            total++;
            bad++;
            me = dq0.pop_front();
            $display("FAIL d0_resp: got no response, want data=%h at cycle %0d", me.data, me.due);
        end
        if (d_valid[1] === 1'b1) begin
            total++;
            if (dq1.size() == 0) begin
                bad++;
                $display("FAIL d1_resp: got unexpected data=%h err=%b at cycle %0d, want none",
                         d_rdata[1], d_err[1], cyc);
            end else begin
                me = dq1.pop_front();
                if (d_rdata[1] !== me.data || d_err[1] !== me.err || cyc != me.due) begin
                    bad++;
                    $display("FAIL d1_resp: got data=%h err=%b cyc=%0d, want data=%h err=%b cyc=%0d",
                             d_rdata[1], d_err[1], cyc, me.data, me.err, me.due);
                end
            end
        end else if (dq1.size() != 0 && dq1[0].due <= cyc) begin
            total++;
            bad++;
            me = dq1.pop_front();
            $display("FAIL d1_resp: got no response, want data=%h at cycle %0d", me.data, me.due);
        end
        if (i_valid[0] === 1'b1) begin
            total++;
            if (iq0.size() == 0) begin
                bad++;
                $display("FAIL i0_resp: got unexpected data=%h at cycle %0d, want none",
                         i_rdata[0], cyc);
            end else begin
                me = iq0.pop_front();
                if (i_rdata[0] !== me.data || cyc != me.due) begin
                    bad++;
                    $display("FAIL i0_resp: got data=%h cyc=%0d, want data=%h cyc=%0d",
                             i_rdata[0], cyc, me.data, me.due);
                end
            end
        end else if (iq0.size() != 0 && iq0[0].due <= cyc) begin
            total++;
            bad++;
            me = iq0.pop_front();
            $display("FAIL i0_resp: got no response, want data=%h at cycle %0d", me.data, me.due);
        end
        if (i_valid[1] === 1'b1) begin
            total++;
            if (iq1.size() == 0) begin
                bad++;
                $display("FAIL i1_resp: got unexpected data=%h at cycle %0d, want none",
                         i_rdata[1], cyc);
            end else begin
                me = iq1.pop_front();
                if (i_rdata[1] !== me.data || cyc != me.due) begin
                    bad++;
                    $display("FAIL i1_resp: got data=%h cyc=%0d, want data=%h cyc=%0d",
                             i_rdata[1], cyc, me.data, me.due);
                end
            end
        end else if (iq1.size() != 0 && iq1[0].due <= cyc) begin
            total++;
            bad++;
            me = iq1.pop_front();
            $display("FAIL i1_resp: got no response, want data=%h at cycle %0d", me.data, me.due);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            i_req[u] = 1'b0;
            d_req[u] = 1'b0;
        end
    endtask

    task automatic d_op(input int u, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [AW-1:0] addr, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee, input bit chk);
        exp_t e;
        d_req[u]      = 1'b1;
        d_we[u]       = we;
        d_size[u]     = sz;
        d_unsigned[u] = uns;
        d_addr[u]     = addr;
        d_wdata[u]    = wd;
        e.data = er;
        e.err  = ee;
        e.due  = cyc + lat(u);
        if (chk) begin
            if (u == 0) dq0.push_back(e);
            else        dq1.push_back(e);
        end
    endtask

    task automatic i_op(input int u, input logic [AW-1:0] addr, input logic [31:0] er);
        exp_t e;
        i_req[u]  = 1'b1;
        i_addr[u] = addr;
        e.data = er;
        e.err  = 1'b0;
        e.due  = cyc + lat(u);
        if (u == 0) iq0.push_back(e);
        else        iq1.push_back(e);
    endtask

    task automatic test_reset();
        for (int u = 0; u < 2; u++) begin
            resetn[u] = 1'b0;
            i_req[u] = 1'b0; i_addr[u] = '0;
            d_req[u] = 1'b0; d_we[u] = 1'b0; d_size[u] = 2'b00; d_unsigned[u] = 1'b0;
            d_addr[u] = '0; d_wdata[u] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        resetn[0] = 1'b1;
        resetn[1] = 1'b1;
        tick();
    endtask

    task automatic test_store_load();
        d_op(0, 1'b1, 2'b10, 1'b0, 14'h0010, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1); tick();
        d_op(0, 1'b0, 2'b10, 1'b0, 14'h0010, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1); tick();
        repeat (3) tick();
    endtask

    task automatic test_extend();
        d_op(0, 1'b1, 2'b10, 1'b0, 14'h0010, 32'h11223344, 32'h0, 1'b0, 1'b1); tick();
        d_op(0, 1'b1, 2'b00, 1'b0, 14'h0013, 32'hFFFFFF80, 32'h0, 1'b0, 1'b1); tick();
        d_op(0, 1'b0, 2'b00, 1'b0, 14'h0013, 32'h0, 32'hFFFFFF80, 1'b0, 1'b1); tick();
        d_op(0, 1'b0, 2'b00, 1'b1, 14'h0013, 32'h0, 32'h00000080, 1'b0, 1'b1); tick();
        d_op(0, 1'b0, 2'b10, 1'b1, 14'h0010, 32'h0, 32'h80223344, 1'b0, 1'b1); tick();
        d_op(0, 1'b0, 2'b01, 1'b0, 14'h0012, 32'h0, 32'hFFFF8022, 1'b0, 1'b1); tick();
        d_op(0, 1'b0, 2'b01, 1'b1, 14'h0010, 32'h0, 32'h00003344, 1'b0, 1'b1); tick();
        repeat (3) tick();
    endtask

    task automatic test_misaligned();
        d_op(0, 1'b0, 2'b01, 1'b0, 14'h0011, 32'h0, 32'h0, 1'b1, 1'b1); tick();
        d_op(0, 1'b1, 2'b10, 1'b0, 14'h0012, 32'hCAFEF00D, 32'h0, 1'b1, 1'b1); tick();
        d_op(0, 1'b1, 2'b11, 1'b0, 14'h0010, 32'hCAFEF00D, 32'h0, 1'b1, 1'b1); tick();
        d_op(0, 1'b0, 2'b11, 1'b0, 14'h0010, 32'h0, 32'h0, 1'b1, 1'b1); tick();
        d_op(0, 1'b0, 2'b10, 1'b0, 14'h0010, 32'h0, 32'h80223344, 1'b0, 1'b1); tick();
        repeat (3) tick();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            d_op(1, 1'b1, 2'b10, 1'b0, 14'(4 * k), 32'(k + 1), 32'h0, 1'b0, 1'b1);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            i_op(1, 14'(4 * k), 32'(k + 1));
            tick();
        end
        i_op(1, 14'h0007, 32'd2); tick();
        repeat (5) tick();
    endtask

    task automatic test_reset_inflight();
        d_op(1, 1'b1, 2'b10, 1'b0, 14'h0040, 32'h0, 32'h0, 1'b0, 1'b1); tick();
        repeat (4) tick();
        d_op(1, 1'b0, 2'b10, 1'b0, 14'h0040, 32'h0, 32'h0, 1'b0, 1'b0); tick();
        d_op(1, 1'b0, 2'b10, 1'b0, 14'h0000, 32'h0, 32'h0, 1'b0, 1'b0); tick();
        resetn[1] = 1'b0;
        d_op(1, 1'b1, 2'b10, 1'b0, 14'h0040, 32'h12345678, 32'h0, 1'b0, 1'b0); tick();
        resetn[1] = 1'b1;
        repeat (6) tick();
        d_op(1, 1'b0, 2'b10, 1'b0, 14'h0040, 32'h0, 32'h0, 1'b0, 1'b1); tick();
        repeat (5) tick();
    endtask

    task automatic test_same_cycle_fetch();
        logic [31:0] exp_fetch;
`ifdef MEM_FWD_EN
        exp_fetch = 32'hABCD0000;
`else
        exp_fetch = 32'h00000000;
`endif
        d_op(0, 1'b1, 2'b10, 1'b0, 14'h0020, 32'h0, 32'h0, 1'b0, 1'b1); tick();
        d_op(0, 1'b1, 2'b01, 1'b0, 14'h0022, 32'h0000ABCD, 32'h0, 1'b0, 1'b1);
        i_op(0, 14'h0020, exp_fetch);
        tick();
        i_op(0, 14'h0020, 32'hABCD0000); tick();
        repeat (3) tick();
    endtask

    task automatic test_random_data();
        logic [31:0] m [16];
        for (int w = 0; w < 16; w++) begin
            m[w] = $urandom;
            d_op(0, 1'b1, 2'b10, 1'b0, 14'(14'h100 + 4 * w), m[w], 32'h0, 1'b0, 1'b1);
            tick();
        end
        for (int n = 0; n < 60; n++) begin
            int          w;
            int          lane;
            logic [1:0]  sz;
            logic        we;
            logic        uns;
            logic        ok;
            logic [31:0] wd;
            logic [31:0] er;
            logic [7:0]  b8;
            logic [15:0] h16;
            w    = $urandom_range(0, 15);
            lane = $urandom_range(0, 3);
            sz   = 2'($urandom_range(0, 3));
            we   = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            wd   = $urandom;
            ok   = (sz == 2'b00) || (sz == 2'b01 && (lane == 0 || lane == 2)) ||
                   (sz == 2'b10 && lane == 0);
            er   = 32'h0;
            if (ok && we) begin
                if (sz == 2'b00)      m[w][8*lane +: 8]  = wd[7:0];
                else if (sz == 2'b01) m[w][8*lane +: 16] = wd[15:0];
                else                  m[w] = wd;
            end else if (ok) begin
                b8  = m[w][8*lane +: 8];
                h16 = (lane == 0) ? m[w][15:0] : m[w][31:16];
                if (sz == 2'b00)      er = uns ? {24'b0, b8} : {{24{b8[7]}}, b8};
                else if (sz == 2'b01) er = uns ? {16'b0, h16} : {{16{h16[15]}}, h16};
                else                  er = m[w];
            end
            d_op(0, we, sz, uns, 14'(14'h100 + 4 * w + lane), wd, er, ~ok, 1'b1);
            tick();
        end
        for (int w = 0; w < 16; w++) begin
            i_op(0, 14'(14'h100 + 4 * w), m[w]);
            tick();
        end
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_extend();
        test_misaligned();
        test_back_to_back();
        test_reset_inflight();
        test_same_cycle_fetch();
        test_random_data();
        repeat (4) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
